// File: rtl/gen_sequencer_if.sv
// Sample stream between gen_sequencer (master) and the downstream filter (slave).
// A sample transfers on a rising clk edge where sample_valid && sample_ready.
interface gen_sequencer_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;
   logic              sample_ready;

   modport master (output sample_out, output sample_valid, input sample_ready);
   modport slave  (input sample_out, input sample_valid, output sample_ready);
endinterface

// File: rtl/gen_sequencer.sv
// Sample-rate scheduler for the sine ROM: divides clk to the sample rate, reads the ROM
// and streams samples to the filter. Define GEN_SEQ_GAIN_EN to add the gain_shift input.
module gen_sequencer #(
   parameter int TABLE_LEN = 40,
   parameter int ADDR_W    = 6,
   parameter int DATA_W    = 24,
   parameter int DIV_W     = 16,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [DIV_W-1:0]  div,
   input  logic [CNT_W-1:0]  n_samples,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   gen_sequencer_if.master   strm,
`ifdef GEN_SEQ_GAIN_EN
   input  logic [2:0]        gain_shift,
`endif
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  overrun_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      FETCH,
      CAPTURE,
      PRESENT,
      DONE
   } state_t;

   localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TABLE_LEN - 1);

   state_t            state;
   logic [DIV_W-1:0]  divider;
   logic [DIV_W-1:0]  div_eff;
   logic [CNT_W-1:0]  n_lat;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  ovr_next;
   logic              tick;
   logic              handshake;
   logic [DATA_W-1:0] shaped;

   assign busy       = (state != IDLE);
   assign tick       = busy && (divider == div_eff);
   assign handshake  = strm.sample_valid && strm.sample_ready;
   assign count_next = count + 1'b1;
   assign ovr_next   = (overrun_cnt == '1) ? overrun_cnt : overrun_cnt + 1'b1;

`ifdef GEN_SEQ_GAIN_EN
   logic [2:0] gain_lat;
   assign shaped = DATA_W'($signed(rom_data) >>> gain_lat);
`else
   assign shaped = rom_data;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         divider           <= '0;
         div_eff           <= DIV_MIN;
         n_lat             <= '0;
         count             <= '0;
         rom_addr          <= '0;
         strm.sample_out   <= '0;
         strm.sample_valid <= 1'b0;
         done              <= 1'b0;
         overrun_cnt       <= '0;
`ifdef GEN_SEQ_GAIN_EN
         gain_lat          <= '0;
`endif
      end else if (state == IDLE) begin
         if (start) begin
            div_eff     <= (div < DIV_MIN) ? DIV_MIN : div;
            n_lat       <= n_samples;
            divider     <= '0;
            rom_addr    <= '0;
            count       <= '0;
            overrun_cnt <= '0;
`ifdef GEN_SEQ_GAIN_EN
            gain_lat    <= gain_shift;
`endif
            state       <= WAIT_TICK;
         end
      end else begin
         divider <= tick ? '0 : divider + 1'b1;
         // stop outranks everything, including a handshake on the same edge
         if (stop) begin
            state             <= IDLE;
            strm.sample_valid <= 1'b0;
            done              <= 1'b0;
         end else begin
            case (state)
               WAIT_TICK: begin
                  if (tick) state <= FETCH;
               end
               FETCH: begin
                  if (tick) overrun_cnt <= ovr_next;
                  state <= CAPTURE;
               end
               CAPTURE: begin
                  if (tick) overrun_cnt <= ovr_next;
                  strm.sample_out   <= shaped;
                  strm.sample_valid <= 1'b1;
                  rom_addr          <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + 1'b1;
                  state             <= PRESENT;
               end
               PRESENT: begin
                  // a tick landing on the handshake edge is neither an overrun nor carried over
                  if (handshake) begin
                     strm.sample_valid <= 1'b0;
                     count             <= count_next;
                     if ((n_lat != '0) && (count_next == n_lat)) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        state <= WAIT_TICK;
                     end
                  end else if (tick) begin
                     overrun_cnt <= ovr_next;
                  end
               end
               DONE: begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gen_sequencer.sv
// Scoreboard bench for gen_sequencer: stimulus pushes expected samples, a negedge monitor
// pops and compares on each handshake (data and spacing in cycles).
module tb_gen_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic [15:0] div;
   logic [15:0] n_samples;
   logic [5:0]  rom_addr;
   logic [23:0] rom_data;
   logic [2:0]  gain_shift;
   logic        busy;
   logic        done;
   logic [15:0] overrun_cnt;

   gen_sequencer_if #(.DATA_W(24)) strm_if ();

   gen_sequencer #(
      .TABLE_LEN(40),
      .ADDR_W   (6),
      .DATA_W   (24),
      .DIV_W    (16),
      .CNT_W    (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .div        (div),
      .n_samples  (n_samples),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .strm       (strm_if),
`ifdef GEN_SEQ_GAIN_EN
      .gain_shift (gain_shift),
`endif
      .busy       (busy),
      .done       (done),
      .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   logic [23:0] rom [0:63];
   always @(posedge clk) rom_data <= rom[rom_addr];

   typedef struct {
      logic [23:0] data;
      int          gap;   // cycles since previous handshake, -1 = unchecked
   } exp_t;

   exp_t q[$];
   exp_t e;
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_hs = 0;
   int hs_count = 0;
   int done_cnt = 0;
   int base;
   int dsnap;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [23:0] d, input int g);
      exp_t x;
      x.data = d;
      x.gap  = g;
      q.push_back(x);
   endtask

   always @(posedge clk) cyc++;

   // monitor: data must match the head of the queue for every valid cycle
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!reset && strm_if.sample_valid) begin
         check("queue_has_entry", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q[0];
            check("sample_out", strm_if.sample_out, e.data);
            if (strm_if.sample_ready && !stop) begin
               if (e.gap >= 0) check("sample_gap", cyc - last_hs, e.gap);
               last_hs = cyc;
               void'(q.pop_front());
               hs_count++;
            end
         end
      end
   end

   task automatic start_run(input logic [15:0] d, input logic [15:0] n);
      @(posedge clk); #1;
      div = d;
      n_samples = n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic stop_run();
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
   endtask

   task automatic wait_hs(input int target, input int budget, input string name);
      int k = 0;
      while (hs_count < target && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check(name, hs_count, target);
   endtask

   task automatic wait_done(input int budget, input string name);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check(name, done, 1);
   endtask

   task automatic wait_valid(input int budget, input string name);
      int k = 0;
      while (!strm_if.sample_valid && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check(name, strm_if.sample_valid, 1);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = (i < 40) ? 24'(i) : 24'd0;
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      div = '0;
      n_samples = '0;
      gain_shift = '0;
      strm_if.sample_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // quiet after reset with no start
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle_quiet", {busy, strm_if.sample_valid, rom_addr, overrun_cnt}, 0);
      end

      // burst of 5, period 10
      strm_if.sample_ready = 1'b1;
      for (int k = 0; k < 5; k++) push(24'(k), (k == 0) ? -1 : 10);
      dsnap = done_cnt;
      start_run(16'd9, 16'd5);
      wait_done(200, "burst_done_seen");
      check("burst_busy_at_done", busy, 1);
      @(negedge clk); #1;
      check("burst_busy_after_done", busy, 0);
      check("burst_done_one_cycle", done, 0);
      repeat (5) @(negedge clk);
      #1;
      check("burst_done_count", done_cnt - dsnap, 1);
      check("burst_drained", q.size(), 0);

      // div below minimum is clamped to 3: period 4
      for (int k = 0; k < 3; k++) push(24'(k), (k == 0) ? -1 : 4);
      start_run(16'd0, 16'd3);
      wait_done(100, "minDiv_done_seen");
      check("minDiv_overrun", overrun_cnt, 0);
      repeat (3) @(negedge clk);

      // continuous, 90 samples across two wraps; start mid-run must be ignored
      base = hs_count;
      for (int k = 0; k < 90; k++) push(24'(k % 40), (k == 0) ? -1 : 5);
      start_run(16'd4, 16'd0);
      wait_hs(base + 20, 200, "cont_reach20");
      start_run(16'd20, 16'd7);
      wait_hs(base + 90, 600, "cont_reach90");
      stop_run();
      @(negedge clk); #1;
      check("cont_busy_after_stop", busy, 0);
      check("cont_overrun", overrun_cnt, 0);
      check("cont_rom_addr_held", rom_addr, 10);

      // filter stall: 35 cycles of ready=0 across three ticks
      base = hs_count;
      strm_if.sample_ready = 1'b0;
      push(24'd0, -1);
      push(24'd1, 5);
      start_run(16'd9, 16'd0);
      wait_valid(100, "stall_valid_seen");
      repeat (35) @(posedge clk);
      #1 strm_if.sample_ready = 1'b1;
      wait_hs(base + 2, 100, "stall_reach2");
      stop_run();
      @(negedge clk); #1;
      check("stall_overrun", overrun_cnt, 3);
      check("stall_busy_after_stop", busy, 0);

      // stop coinciding with a handshake in PRESENT
      base = hs_count;
      dsnap = done_cnt;
      strm_if.sample_ready = 1'b0;
      push(24'd0, -1);
      start_run(16'd9, 16'd0);
      wait_valid(100, "stopHs_valid_seen");
      @(posedge clk); #1;
      strm_if.sample_ready = 1'b1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      strm_if.sample_ready = 1'b0;
      @(negedge clk); #1;
      check("stopHs_busy", busy, 0);
      check("stopHs_valid", strm_if.sample_valid, 0);
      check("stopHs_no_done", done_cnt - dsnap, 0);
      check("stopHs_no_transfer", hs_count - base, 0);
      check("stopHs_rom_addr_held", rom_addr, 1);
      if (q.size() != 0) void'(q.pop_front());

      // asynchronous reset while in FETCH
      base = hs_count;
      strm_if.sample_ready = 1'b1;
      for (int k = 0; k < 3; k++) push(24'(k), (k == 0) ? -1 : 10);
      start_run(16'd9, 16'd0);
      wait_hs(base + 3, 200, "rst_reach3");
      repeat (8) @(posedge clk);
      #2;
      check("rst_pre_rom_addr", rom_addr, 3);
      check("rst_pre_sample_out", strm_if.sample_out, 2);
      reset = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", strm_if.sample_valid, 0);
      check("rst_done", done, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_overrun", overrun_cnt, 0);
      check("rst_sample_out", strm_if.sample_out, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      strm_if.sample_ready = 1'b0;

`ifdef GEN_SEQ_GAIN_EN
      rom[0] = -24'sd6000000;
      rom[1] = 24'd7;
      gain_shift = 3'd2;
      strm_if.sample_ready = 1'b1;
      push(-24'sd1500000, -1);
      push(24'd1, 10);
      start_run(16'd9, 16'd2);
      wait_done(100, "gain_done_seen");
      repeat (3) @(negedge clk);
`endif

      repeat (5) @(negedge clk);
      #1;
      check("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
